// File: rtl/ramb_asym_dp.sv
// rtl/ramb_asym_dp.sv - single-clock true dual-port RAM with asymmetric port widths,
// optional output register and deterministic collision handling.
module ramb_asym_dp #(
  parameter int                         WIDTH_A      = 1,
  parameter int                         RATIO        = 2,
  parameter int                         DEPTH_A      = 16384,
  parameter string                      WRITE_MODE_A = "WRITE_FIRST",
  parameter string                      WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [WIDTH_A-1:0]         INIT_A       = '0,
  parameter logic [WIDTH_A*RATIO-1:0]   INIT_B       = '0,
  parameter logic [WIDTH_A-1:0]         SRVAL_A      = '0,
  parameter logic [WIDTH_A*RATIO-1:0]   SRVAL_B      = '0,
  parameter bit                         DO_REG       = 1'b0,
  parameter int                         CNT_W        = 16,
  localparam int                        WIDTH_B      = WIDTH_A * RATIO,
  localparam int                        DEPTH_B      = DEPTH_A / RATIO,
  localparam int                        AW_A         = (DEPTH_A > 1) ? $clog2(DEPTH_A) : 1,
  localparam int                        AW_B         = (DEPTH_B > 1) ? $clog2(DEPTH_B) : 1
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic               ENA,
  input  logic               WEA,
  input  logic               SSRA,
  input  logic [AW_A-1:0]    ADDRA,
  input  logic [WIDTH_A-1:0] DIA,
  output logic [WIDTH_A-1:0] DOA,
  input  logic               ENB,
  input  logic               WEB,
  input  logic               SSRB,
  input  logic [AW_B-1:0]    ADDRB,
  input  logic [WIDTH_B-1:0] DIB,
  output logic [WIDTH_B-1:0] DOB,
  output logic               COLL,
  output logic [CNT_W-1:0]   COLL_CNT,
  input  logic               COLL_CLR
);

  localparam int LW  = $clog2(RATIO);
  localparam int LWS = (LW > 0) ? LW : 1;

  localparam logic [1:0] M_WF = 2'd0;
  localparam logic [1:0] M_RF = 2'd1;
  localparam logic [1:0] M_NC = 2'd2;
  localparam logic [1:0] M_BAD = 2'd3;

  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? M_WF :
                                  (WRITE_MODE_A == "READ_FIRST")  ? M_RF :
                                  (WRITE_MODE_A == "NO_CHANGE")   ? M_NC : M_BAD;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? M_WF :
                                  (WRITE_MODE_B == "READ_FIRST")  ? M_RF :
                                  (WRITE_MODE_B == "NO_CHANGE")   ? M_NC : M_BAD;

  if (RATIO < 1 || RATIO > 32 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("ramb_asym_dp: RATIO must be a power of two in 1..32");
  end
  if ((DEPTH_A % RATIO) != 0 || (DEPTH_A & (DEPTH_A - 1)) != 0) begin : g_bad_depth
    $error("ramb_asym_dp: DEPTH_A must be a power of two divisible by RATIO");
  end
  if (MODE_A == M_BAD) begin : g_bad_mode_a
    $error("ramb_asym_dp: illegal WRITE_MODE_A");
  end
  if (MODE_B == M_BAD) begin : g_bad_mode_b
    $error("ramb_asym_dp: illegal WRITE_MODE_B");
  end

  // Storage is organised as wide B words; port A addresses one lane of a word.
  logic [WIDTH_B-1:0] r_mem [DEPTH_B] = '{default: '0};

  logic [AW_B-1:0]    w_addra_hi;
  logic [LWS-1:0]     w_lane_a;
  logic [WIDTH_B-1:0] w_worda;
  logic [WIDTH_A-1:0] w_rda;
  logic [WIDTH_B-1:0] w_rdb;
  logic               w_coll;

  logic [WIDTH_A-1:0] r_doa1;
  logic [WIDTH_B-1:0] r_dob1;
  logic               r_coll;
  logic [CNT_W-1:0]   r_coll_cnt;

  assign w_addra_hi = AW_B'(ADDRA >> LW);

  if (RATIO > 1) begin : g_lane
    assign w_lane_a = ADDRA[LWS-1:0];
  end else begin : g_nolane
    assign w_lane_a = '0;
  end

  assign w_worda = r_mem[w_addra_hi];
  assign w_rda   = w_worda[int'(w_lane_a)*WIDTH_A +: WIDTH_A];
  assign w_rdb   = r_mem[ADDRB];

  assign w_coll = ENA && ENB && (w_addra_hi == ADDRB) && (WEA || WEB);

  // Port B is written after port A so it wins a write/write collision on the shared lane.
  // RSTN is sampled at the edge: a write is dropped only while reset is still asserted.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      if (ENA && WEA) begin
        r_mem[w_addra_hi][int'(w_lane_a)*WIDTH_A +: WIDTH_A] <= DIA;
      end
      if (ENB && WEB) begin
        r_mem[ADDRB] <= DIB;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_doa1 <= INIT_A;
    end else if (ENA) begin
      if (SSRA) begin
        r_doa1 <= SRVAL_A;
      end else if (!WEA) begin
        r_doa1 <= w_rda;
      end else if (MODE_A == M_WF) begin
        r_doa1 <= DIA;
      end else if (MODE_A == M_RF) begin
        r_doa1 <= w_rda;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_dob1 <= INIT_B;
    end else if (ENB) begin
      if (SSRB) begin
        r_dob1 <= SRVAL_B;
      end else if (!WEB) begin
        r_dob1 <= w_rdb;
      end else if (MODE_B == M_WF) begin
        r_dob1 <= DIB;
      end else if (MODE_B == M_RF) begin
        r_dob1 <= w_rdb;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_coll     <= 1'b0;
      r_coll_cnt <= '0;
    end else begin
      r_coll <= w_coll;
      if (COLL_CLR) begin
        r_coll_cnt <= '0;
      end else if (w_coll && (r_coll_cnt != {CNT_W{1'b1}})) begin
        r_coll_cnt <= r_coll_cnt + 1'b1;
      end
    end
  end

  if (DO_REG) begin : g_oreg
    logic [WIDTH_A-1:0] r_doa2;
    logic [WIDTH_B-1:0] r_dob2;

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        r_doa2 <= INIT_A;
        r_dob2 <= INIT_B;
      end else begin
        r_doa2 <= r_doa1;
        r_dob2 <= r_dob1;
      end
    end

    assign DOA = r_doa2;
    assign DOB = r_dob2;
  end else begin : g_noreg
    assign DOA = r_doa1;
    assign DOB = r_dob1;
  end

  assign COLL     = r_coll;
  assign COLL_CNT = r_coll_cnt;

endmodule

// File: tb/tb_ramb_asym_dp.sv
// tb/tb_ramb_asym_dp.sv - scoreboard bench: three RAM variants (mode/DO_REG mixes)
// driven with shared stimulus and compared against an array-based reference model.
module tb_ramb_asym_dp;

  localparam int WA = 2;
  localparam int R  = 4;
  localparam int DA = 32;
  localparam int WB = WA * R;
  localparam logic [WA-1:0] P_INIT_A  = 2'd1;
  localparam logic [WB-1:0] P_INIT_B  = 8'h5A;
  localparam logic [WA-1:0] P_SRVAL_A = 2'd2;
  localparam logic [WB-1:0] P_SRVAL_B = 8'hC3;

  logic       CLK = 1'b0;
  logic       RSTN, ENA, WEA, SSRA, ENB, WEB, SSRB, COLL_CLR;
  logic [4:0] ADDRA;
  logic [2:0] ADDRB;
  logic [1:0] DIA;
  logic [7:0] DIB;

  logic [2:0][1:0] doa;
  logic [2:0][7:0] dob;
  logic [2:0]      coll;
  logic [2:0][1:0] cnt;

  always #5 CLK = ~CLK;

  ramb_asym_dp #(.WIDTH_A(WA), .RATIO(R), .DEPTH_A(DA), .WRITE_MODE_A("WRITE_FIRST"),
    .WRITE_MODE_B("READ_FIRST"), .INIT_A(P_INIT_A), .INIT_B(P_INIT_B), .SRVAL_A(P_SRVAL_A),
    .SRVAL_B(P_SRVAL_B), .DO_REG(1'b0), .CNT_W(2)) u_d0 (
    .CLK(CLK), .RSTN(RSTN), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DOA(doa[0]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob[0]),
    .COLL(coll[0]), .COLL_CNT(cnt[0]), .COLL_CLR(COLL_CLR));

  ramb_asym_dp #(.WIDTH_A(WA), .RATIO(R), .DEPTH_A(DA), .WRITE_MODE_A("READ_FIRST"),
    .WRITE_MODE_B("NO_CHANGE"), .INIT_A(P_INIT_A), .INIT_B(P_INIT_B), .SRVAL_A(P_SRVAL_A),
    .SRVAL_B(P_SRVAL_B), .DO_REG(1'b1), .CNT_W(2)) u_d1 (
    .CLK(CLK), .RSTN(RSTN), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DOA(doa[1]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob[1]),
    .COLL(coll[1]), .COLL_CNT(cnt[1]), .COLL_CLR(COLL_CLR));

  ramb_asym_dp #(.WIDTH_A(WA), .RATIO(R), .DEPTH_A(DA), .WRITE_MODE_A("NO_CHANGE"),
    .WRITE_MODE_B("WRITE_FIRST"), .INIT_A(P_INIT_A), .INIT_B(P_INIT_B), .SRVAL_A(P_SRVAL_A),
    .SRVAL_B(P_SRVAL_B), .DO_REG(1'b0), .CNT_W(2)) u_d2 (
    .CLK(CLK), .RSTN(RSTN), .ENA(ENA), .WEA(WEA), .SSRA(SSRA), .ADDRA(ADDRA), .DIA(DIA),
    .DOA(doa[2]), .ENB(ENB), .WEB(WEB), .SSRB(SSRB), .ADDRB(ADDRB), .DIB(DIB), .DOB(dob[2]),
    .COLL(coll[2]), .COLL_CNT(cnt[2]), .COLL_CLR(COLL_CLR));

  // Per-variant configuration: mode 0=WRITE_FIRST, 1=READ_FIRST, 2=NO_CHANGE.
  int ma [3] = '{0, 1, 2};
  int mb [3] = '{1, 2, 0};
  bit dr [3] = '{1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic [2:0][1:0] doa;
    logic [2:0][7:0] dob;
    logic            coll;
    logic [1:0]      cnt;
  } exp_t;

  exp_t sb_q[$];
  bit   armed = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0] m_mem [DA];
  logic [2:0][1:0] s1a, s2a;
  logic [2:0][7:0] s1b, s2b;
  logic       m_coll;
  int         m_cnt;

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, i, $time, act, exp);
    end
  endtask

  task automatic model(input bit rstn, ena, wea, ssra, input int aa, input logic [1:0] da,
                       input bit enb, web, ssrb, input int ab, input logic [7:0] db, input bit clr);
    logic [1:0] olda;
    logic [7:0] oldb;
    bit c;
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        s1a[i] = P_INIT_A; s2a[i] = P_INIT_A; s1b[i] = P_INIT_B; s2b[i] = P_INIT_B;
      end
      m_coll = 1'b0;
      m_cnt  = 0;
    end else begin
      olda = m_mem[aa];
      for (int k = 0; k < R; k++) oldb[k*WA +: WA] = m_mem[ab*R + k];
      for (int i = 0; i < 3; i++) begin
        s2a[i] = s1a[i];
        s2b[i] = s1b[i];
        if (ena) begin
          if (ssra) s1a[i] = P_SRVAL_A;
          else if (!wea || ma[i] == 1) s1a[i] = olda;
          else if (ma[i] == 0) s1a[i] = da;
        end
        if (enb) begin
          if (ssrb) s1b[i] = P_SRVAL_B;
          else if (!web || mb[i] == 1) s1b[i] = oldb;
          else if (mb[i] == 0) s1b[i] = db;
        end
      end
      c = ena && enb && (aa / R == ab) && (wea || web);
      m_coll = c;
      if (clr) m_cnt = 0;
      else if (c && m_cnt < 3) m_cnt = m_cnt + 1;
      if (ena && wea) m_mem[aa] = da;
      if (enb && web) for (int k = 0; k < R; k++) m_mem[ab*R + k] = db[k*WA +: WA];
    end
  endtask

  task automatic cyc(input bit rstn, ena, wea, ssra, input int aa, input logic [1:0] da,
                     input bit enb, web, ssrb, input int ab, input logic [7:0] db, input bit clr);
    exp_t e;
    @(negedge CLK);
    RSTN = rstn; ENA = ena; WEA = wea; SSRA = ssra; ADDRA = 5'(aa); DIA = da;
    ENB = enb; WEB = web; SSRB = ssrb; ADDRB = 3'(ab); DIB = db; COLL_CLR = clr;
    model(rstn, ena, wea, ssra, aa, da, enb, web, ssrb, ab, db, clr);
    for (int i = 0; i < 3; i++) begin
      e.doa[i] = dr[i] ? s2a[i] : s1a[i];
      e.dob[i] = dr[i] ? s2b[i] : s1b[i];
    end
    e.coll = m_coll;
    e.cnt  = 2'(m_cnt);
    sb_q.push_back(e);
    armed = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (armed) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty t=%0t: got 0 entries expected 1", $time);
        end else begin
          e = sb_q.pop_front();
          for (int i = 0; i < 3; i++) begin
            chk("doa", i, 8'(doa[i]), 8'(e.doa[i]));
            chk("dob", i, dob[i], e.dob[i]);
            chk("coll", i, 8'(coll[i]), 8'(e.coll));
            chk("coll_cnt", i, 8'(cnt[i]), 8'(e.cnt));
          end
        end
      end
    end
  end

  initial begin : stimulus
    for (int a = 0; a < DA; a++) m_mem[a] = '0;
    RSTN = 1'b0; ENA = 1'b0; WEA = 1'b0; SSRA = 1'b0; ADDRA = '0; DIA = '0;
    ENB = 1'b0; WEB = 1'b0; SSRB = 1'b0; ADDRB = '0; DIB = '0; COLL_CLR = 1'b0;

    // reset held, writes attempted while in reset must not land
    cyc(0, 1, 1, 0, 5, 2'd3, 1, 1, 0, 6, 8'hFF, 0);
    cyc(0, 1, 1, 0, 5, 2'd3, 0, 0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);
    // first read after release
    cyc(1, 1, 0, 0, 5, 2'd0, 1, 0, 0, 6, 8'h00, 0);
    // asymmetric mapping
    cyc(1, 1, 1, 0, 6, 2'd1, 0, 0, 0, 0, 8'h00, 0);
    cyc(1, 1, 1, 0, 7, 2'd2, 0, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 0, 2'd0, 1, 0, 0, 1, 8'h00, 0);
    cyc(1, 0, 0, 0, 0, 2'd0, 1, 1, 0, 2, 8'hE4, 0);
    cyc(1, 1, 0, 0, 9, 2'd0, 0, 0, 0, 0, 8'h00, 0);
    // write modes on A0, then B0 with old value visible
    cyc(1, 1, 1, 0, 0, 2'd3, 0, 0, 0, 0, 8'h00, 0);
    cyc(1, 1, 1, 0, 0, 2'd1, 1, 0, 0, 5, 8'h00, 0);
    cyc(1, 0, 0, 0, 0, 2'd0, 1, 1, 0, 0, 8'h9C, 0);
    // synchronous set/reset with a write underneath, then read back
    cyc(1, 1, 1, 1, 16, 2'd3, 1, 1, 1, 2, 8'h00, 0);
    cyc(1, 1, 0, 0, 16, 2'd0, 1, 0, 0, 2, 8'h00, 0);
    // write/write collision: B wins on the shared lane
    cyc(1, 1, 1, 0, 8, 2'd3, 1, 1, 0, 2, 8'h1B, 0);
    cyc(1, 1, 0, 0, 8, 2'd0, 1, 0, 0, 2, 8'h00, 0);
    // read/write collisions both ways
    cyc(1, 1, 0, 0, 9, 2'd0, 1, 1, 0, 2, 8'h77, 0);
    cyc(1, 1, 1, 0, 10, 2'd0, 1, 0, 0, 2, 8'h00, 0);
    // saturate then clear together with a collision
    for (int n = 0; n < 5; n++) cyc(1, 1, 1, 0, 12, 2'(n), 1, 0, 0, 3, 8'h00, 0);
    cyc(1, 1, 1, 0, 12, 2'd2, 1, 1, 0, 3, 8'hA5, 1);
    cyc(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);

    // randomized traffic with a small address window to provoke collisions, reset mid-run
    for (int n = 0; n < 400; n++) begin
      cyc(!(n >= 200 && n < 202),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 15)), 2'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 15) == 0);
    end
    cyc(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);
    cyc(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 0);

    @(posedge CLK);
    #4;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
